mlp_neuron_mac: RTL and testbench

Parametrised single-neuron MAC engine for the MLP datapath. It accepts a stream of signed (input, weight) pairs over a valid/ready handshake and accumulates them with saturation, starting from a per-vector bias. On the beat flagged last it produces a requantised, optionally ReLU'd output over a second valid/ready handshake. It generalises the fixed 4x4-bit, 16-bit accumulate/ReLU neuron with configurable widths, bias, shift and overflow reporting.

---
 rtl/mlp_neuron_mac.sv | 94 +++++++++
 tb/tb_mlp_neuron_mac.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mlp_neuron_mac.sv
// mlp_neuron_mac: streaming signed MAC neuron with bias, saturating accumulate,
// shift requantisation and optional ReLU over valid/ready handshakes.
module mlp_neuron_mac #(
    parameter int IN_W    = 4,
    parameter int WT_W    = 4,
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_relu,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic signed [ACC_W-1:0]   bias_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_W-1:0]    in_x,
    input  logic signed [WT_W-1:0]    in_w,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic signed [ACC_W-1:0]   out_acc,
    output logic                      out_ovf
);
    localparam logic [1:0] ACCUM = 2'd0, DRAIN = 2'd1, HOLD = 2'd2;
    localparam int PW = IN_W + WT_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    logic [1:0] state;
    logic first, p_valid, p_first, relu_r, ovf, accept, sat;
    logic [SHIFT_W-1:0] shift_r;
    logic signed [PW-1:0] prod;
    logic signed [ACC_W-1:0] acc, bias_r, base, shifted;
    logic signed [ACC_W:0] sum;
    logic signed [OUT_W-1:0] clip;

    assign in_ready  = state == ACCUM;
    assign out_valid = state == HOLD;
    assign accept    = in_valid && in_ready;
    assign base      = p_first ? bias_r : acc;
    assign sum       = {base[ACC_W-1], base} + {{(ACC_W+1-PW){prod[PW-1]}}, prod};
    // Top two bits of the widened sum disagree exactly when it left the ACC_W range.
    assign sat       = sum[ACC_W] != sum[ACC_W-1];
    assign shifted   = acc >>> shift_r;
    assign clip      = shifted > OUT_MAX ? OUT_MAX[OUT_W-1:0] :
                       shifted < OUT_MIN ? OUT_MIN[OUT_W-1:0] : shifted[OUT_W-1:0];
    assign out_data  = (relu_r && clip[OUT_W-1]) ? '0 : clip;
    assign out_acc   = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            first   <= 1'b1;
            p_valid <= 1'b0;
            p_first <= 1'b0;
            prod    <= '0;
            acc     <= '0;
            bias_r  <= '0;
            relu_r  <= 1'b0;
            shift_r <= '0;
            ovf     <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                prod    <= PW'(in_x) * PW'(in_w);
                p_first <= first;
                first   <= 1'b0;
                if (first) begin
                    bias_r  <= bias_in;
                    relu_r  <= cfg_relu;
                    shift_r <= cfg_shift;
                end
            end
            if (p_valid) begin
                acc <= sat ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
                ovf <= (ovf && !p_first) || sat;
            end
            case (state)
                ACCUM:   if (accept && in_last) state <= DRAIN;
                DRAIN:   if (!p_valid) state <= HOLD;
                HOLD:    if (out_ready) begin
                    state <= ACCUM;
                    first <= 1'b1;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_neuron_mac.sv
// tb_mlp_neuron_mac: directed self-checking bench for mlp_neuron_mac.
module tb_mlp_neuron_mac;
    logic clk = 0, rst_n = 0, cfg_relu = 0;
    logic [3:0] cfg_shift = 0;
    logic signed [15:0] bias_in = 0;
    logic in_valid = 0, in_ready, in_last = 0, out_valid, out_ready = 0, out_ovf;
    logic signed [3:0] in_x = 0, in_w = 0;
    logic signed [7:0] out_data;
    logic signed [15:0] out_acc;
    int errors = 0, checks = 0;
    int xs[6] = '{1, 2, 3, -4, 5, -6};
    int ws[6] = '{7, -3, 2, 5, 4, 1};

    always #5 clk = ~clk;

    mlp_neuron_mac dut (
        .clk(clk), .rst_n(rst_n), .cfg_relu(cfg_relu), .cfg_shift(cfg_shift),
        .bias_in(bias_in), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_w(in_w), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_acc(out_acc), .out_ovf(out_ovf)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input int x, input int w, input bit last);
        in_x = 4'(x);
        in_w = 4'(w);
        in_last = last;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic take();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    initial begin
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1 rst_n = 1;

        beat(3, 2, 0); beat(-2, 5, 0); beat(7, -1, 1);
        check("lat_edge0", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge1", out_valid, 0);
        check("drain_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("lat_edge2", out_valid, 1);
        check("t1_acc", out_acc, -11);
        check("t1_data", out_data, -11);
        check("t1_ovf", out_ovf, 0);
        take();
        cfg_relu = 1;
        beat(3, 2, 0); beat(-2, 5, 0); beat(7, -1, 1);
        wait_out();
        check("t1_relu_data", out_data, 0);
        check("t1_relu_acc", out_acc, -11);
        take();
        cfg_relu = 0;

        bias_in = 32760;
        beat(7, 7, 1);
        wait_out();
        check("t2_acc_sat", out_acc, 32767);
        check("t2_ovf", out_ovf, 1);
        check("t2_data", out_data, 127);
        take();
        cfg_shift = 8;
        beat(7, 7, 1);
        wait_out();
        check("t2_data_sh8", out_data, 127);
        take();
        cfg_shift = 0; bias_in = 0;
        beat(1, 1, 1);
        wait_out();
        check("t2_ovf_clear", out_ovf, 0);
        check("t2_acc_1", out_acc, 1);
        take();

        bias_in = -5;
        beat(-8, -8, 1);
        check("t3_drain_ready", in_ready, 0);
        wait_out();
        check("t3_hold_ready", in_ready, 0);
        check("t3_acc", out_acc, 59);
        check("t3_data", out_data, 59);
        take();

        bias_in = 10;
        beat(3, 3, 1);
        wait_out();
        in_x = 5; in_w = 5; in_last = 1; in_valid = 1;
        bias_in = 100; cfg_shift = 1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("t4_hold_acc", out_acc, 19);
        check("t4_hold_data", out_data, 19);
        check("t4_hold_ready", in_ready, 0);
        check("t4_hold_valid", out_valid, 1);
        in_valid = 0; in_last = 0;
        take();
        beat(2, 3, 1);
        wait_out();
        check("t4_next_acc", out_acc, 106);
        check("t4_next_data", out_data, 53);
        take();

        cfg_shift = 0; bias_in = 0;
        beat(1, 2, 0); beat(3, 4, 0);
        #2 rst_n = 0;
        #1;
        check("t5_mid_valid", out_valid, 0);
        check("t5_mid_acc", out_acc, 0);
        @(posedge clk); #1 rst_n = 1;
        beat(1, 4, 0); beat(1, 4, 1);
        wait_out();
        check("t5_acc", out_acc, 8);
        check("t5_data", out_data, 8);
        #2 rst_n = 0;
        #1;
        check("t5_hold_valid", out_valid, 0);
        check("t5_hold_acc", out_acc, 0);
        check("t5_hold_data", out_data, 0);
        @(posedge clk); #1 rst_n = 1;

        bias_in = 1000; cfg_shift = 3; cfg_relu = 0;
        for (int i = 0; i < 6; i++) begin
            beat(xs[i], ws[i], i == 5);
            bias_in = -7000; cfg_shift = 0; cfg_relu = 1;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_out();
        check("t6_acc", out_acc, 1001);
        check("t6_data", out_data, 125);
        check("t6_ovf", out_ovf, 0);
        take();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
